// File: rtl/chess_pkg.sv
// ============================================================================
// Module      : chess_pkg
// Description : Shared constants, direction encoding and direction-step helper
//               for the chess-value pattern recognition pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chess_pkg;

    localparam int BOARD_SIZE_DEF = 15;
    localparam int WIN_LEN        = 9;
    localparam int WIN_CENTER     = 4;

    typedef enum logic [1:0] {
        DIR_H = 2'd0,
        DIR_V = 2'd1,
        DIR_D = 2'd2,
        DIR_A = 2'd3
    } dir_e;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_MY    = 2'b01;
    localparam logic [1:0] CELL_OP    = 2'b10;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    function automatic delta_t dir_delta(input dir_e d);
        delta_t r;
        r.dx = 2'sd1;
        r.dy = 2'sd0;
        case (d)
            DIR_H: begin r.dx = 2'sd1; r.dy = 2'sd0;  end
            DIR_V: begin r.dx = 2'sd0; r.dy = 2'sd1;  end
            DIR_D: begin r.dx = 2'sd1; r.dy = 2'sd1;  end
            DIR_A: begin r.dx = 2'sd1; r.dy = -2'sd1; end
            default: begin r.dx = 2'sd1; r.dy = 2'sd0; end
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_window_fetch_if.sv
// ============================================================================
// Module      : line_window_fetch_if
// Description : Request, board-RAM read and window hand-off signals of the
//               line window fetcher. Optional macro: LWF_CENTER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_window_fetch_if
    import chess_pkg::*;
#(
    parameter int COORD_W = 4
) ();

    logic               start;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               busy;
    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [1:0]         rd_data;
    logic               win_valid;
    logic               win_ready;
    logic [1:0]         win_dir;
    logic [WIN_LEN-1:0] win_my;
    logic [WIN_LEN-1:0] win_op;
    logic               done;
`ifdef LWF_CENTER_CHECK_EN
    logic               occ_err;
`endif

    modport master (
        input  start, pos_x, pos_y, rd_data, win_ready,
        output busy, rd_en, rd_x, rd_y, win_valid, win_dir, win_my, win_op, done
`ifdef LWF_CENTER_CHECK_EN
        , output occ_err
`endif
    );

    modport slave (
        output start, pos_x, pos_y, rd_data, win_ready,
        input  busy, rd_en, rd_x, rd_y, win_valid, win_dir, win_my, win_op, done
`ifdef LWF_CENTER_CHECK_EN
        , input occ_err
`endif
    );

endinterface

`default_nettype wire

// File: rtl/lwf_addr_gen.sv
// ============================================================================
// Module      : lwf_addr_gen
// Description : Cell coordinate for window index k along a direction, plus
//               on-board check. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lwf_addr_gen
    import chess_pkg::*;
#(
    parameter int BOARD_SIZE = BOARD_SIZE_DEF,
    parameter int COORD_W    = 4
) (
    input  logic [COORD_W-1:0] pos_x_i,
    input  logic [COORD_W-1:0] pos_y_i,
    input  dir_e               dir_i,
    input  logic [3:0]         k_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               inb_o
);

    localparam int CW = COORD_W + 2;
    localparam logic signed [CW-1:0] BOARD_LIM = CW'(BOARD_SIZE);

    delta_t                 w_delta;
    logic signed [CW-1:0]   w_off;
    logic signed [CW-1:0]   w_px;
    logic signed [CW-1:0]   w_py;
    logic signed [CW-1:0]   w_cx;
    logic signed [CW-1:0]   w_cy;

    always_comb begin
        w_delta = dir_delta(dir_i);
        w_off   = $signed(CW'(k_i)) - $signed(CW'(WIN_CENTER));
        w_px    = $signed(CW'(pos_x_i));
        w_py    = $signed(CW'(pos_y_i));

        case (w_delta.dx)
            2'b01:   w_cx = w_px + w_off;
            2'b11:   w_cx = w_px - w_off;
            default: w_cx = w_px;
        endcase

        case (w_delta.dy)
            2'b01:   w_cy = w_py + w_off;
            2'b11:   w_cy = w_py - w_off;
            default: w_cy = w_py;
        endcase

        // Negative results show up as a set sign bit at this width.
        inb_o = !w_cx[CW-1] && (w_cx < BOARD_LIM) &&
                !w_cy[CW-1] && (w_cy < BOARD_LIM);
        x_o   = w_cx[COORD_W-1:0];
        y_o   = w_cy[COORD_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/line_window_fetch.sv
// ============================================================================
// Module      : line_window_fetch
// Description : Reads the 9-cell line windows around a candidate position in
//               four directions and hands them out over valid/ready.
//               Optional macro: LWF_CENTER_CHECK_EN (occupied-centre abort).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_window_fetch
    import chess_pkg::*;
#(
    parameter int BOARD_SIZE = BOARD_SIZE_DEF,
    parameter int COORD_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    line_window_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam logic [3:0] K_LAST   = 4'(WIN_LEN - 1);
    localparam logic [3:0] K_CENTER = 4'(WIN_CENTER);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    dir_e               dir_q, dir_d;
    logic [3:0]         k_q, k_d;
    logic [WIN_LEN-1:0] my_q, my_d;
    logic [WIN_LEN-1:0] op_q, op_d;
    logic               pend_q, pend_d;
    logic               pend_blk_q, pend_blk_d;
    logic [3:0]         pend_idx_q, pend_idx_d;
    logic               done_q, done_d;

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_inb;

`ifdef LWF_CENTER_CHECK_EN
    logic               occ_q, occ_d;
    logic               w_occ_err;
`endif

    lwf_addr_gen #(
        .BOARD_SIZE (BOARD_SIZE),
        .COORD_W    (COORD_W)
    ) u_addr_gen (
        .pos_x_i (pos_x_q),
        .pos_y_i (pos_y_q),
        .dir_i   (dir_q),
        .k_i     (k_q),
        .x_o     (w_x),
        .y_o     (w_y),
        .inb_o   (w_inb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            dir_q      <= DIR_H;
            k_q        <= '0;
            my_q       <= '0;
            op_q       <= '0;
            pend_q     <= 1'b0;
            pend_blk_q <= 1'b0;
            pend_idx_q <= '0;
            done_q     <= 1'b0;
`ifdef LWF_CENTER_CHECK_EN
            occ_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_q      <= dir_d;
            k_q        <= k_d;
            my_q       <= my_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            pend_blk_q <= pend_blk_d;
            pend_idx_q <= pend_idx_d;
            done_q     <= done_d;
`ifdef LWF_CENTER_CHECK_EN
            occ_q      <= occ_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_d      = dir_q;
        k_d        = k_q;
        my_d       = my_q;
        op_d       = op_q;
        pend_d     = 1'b0;
        pend_blk_d = pend_blk_q;
        pend_idx_d = pend_idx_q;
        done_d     = 1'b0;
`ifdef LWF_CENTER_CHECK_EN
        occ_d      = occ_q;
`endif

        // Capture the cell issued in the previous cycle (RAM has one cycle latency).
        if (pend_q) begin
            if (pend_idx_q == K_CENTER) begin
                my_d[pend_idx_q] = 1'b1;
                op_d[pend_idx_q] = 1'b0;
`ifdef LWF_CENTER_CHECK_EN
                occ_d = (dir_q == DIR_H) && !pend_blk_q && (bus.rd_data != CELL_EMPTY);
`endif
            end else if (pend_blk_q) begin
                my_d[pend_idx_q] = 1'b0;
                op_d[pend_idx_q] = 1'b1;
            end else begin
                my_d[pend_idx_q] = (bus.rd_data == CELL_MY);
                op_d[pend_idx_q] = bus.rd_data[1];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pos_x_d = bus.pos_x;
                    pos_y_d = bus.pos_y;
                    dir_d   = DIR_H;
                    k_d     = '0;
                    state_d = ST_READ;
`ifdef LWF_CENTER_CHECK_EN
                    occ_d   = 1'b0;
`endif
                end
            end
            ST_READ: begin
                pend_d     = 1'b1;
                pend_blk_d = !w_inb;
                pend_idx_d = k_q;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = 4'(k_q + 4'd1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
`ifdef LWF_CENTER_CHECK_EN
                if (occ_q && (dir_q == DIR_H)) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_OUT: begin
                if (bus.win_ready) begin
                    if (dir_q == DIR_A) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dir_d   = dir_e'(2'(dir_q + 2'd1));
                        k_d     = '0;
                        state_d = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LWF_CENTER_CHECK_EN
    assign w_occ_err   = (state_q == ST_DRAIN) && occ_q && (dir_q == DIR_H);
    assign bus.occ_err = w_occ_err;
    assign bus.done    = done_q | w_occ_err;
`else
    assign bus.done    = done_q;
`endif

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rd_en     = (state_q == ST_READ) && w_inb;
    assign bus.rd_x      = bus.rd_en ? w_x : '0;
    assign bus.rd_y      = bus.rd_en ? w_y : '0;
    assign bus.win_valid = (state_q == ST_OUT);
    assign bus.win_dir   = dir_q;
    assign bus.win_my    = my_q;
    assign bus.win_op    = op_q;

endmodule

`default_nettype wire
